fifo_write_arbiter: RTL and testbench

- Shares the write port of one 8-bit fifo instance among N_REQ producers.
- Uses round-robin arbitration with bounded bursts.
- Sits between producer blocks and the fifo's wen/wdata inputs, and reads back the fifo's full/count status.
- Never writes into a full fifo, so the fifo's overwrite-oldest path is never exercised through this block.

---
 rtl/fifo_write_arbiter_if.sv | 26 ++
 rtl/fifo_write_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - producer/fifo-side bundle for the fifo write arbiter
interface fifo_write_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int ADDR_BITS = 5
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               fifo_full;
    logic [ADDR_BITS:0] fifo_count;
    logic               fifo_wen;
    logic [7:0]         fifo_wdata;
    logic [N_REQ-1:0]   grant;
    logic               busy;

    modport master (
        output req_valid, req_last, req_data, fifo_full, fifo_count,
        input  req_ready, fifo_wen, fifo_wdata, grant, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full, fifo_count,
        output req_ready, fifo_wen, fifo_wdata, grant, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin bounded-burst arbiter for one fifo write port
// Optional macro ARB_PRIO0_EN: requester 0 gets strict priority in IDLE.
module fifo_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_DATA  = 16,
    parameter int ADDR_BITS = 5,
    parameter int BURST     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_write_arbiter_if.slave   bus
);
    localparam int PTR_W  = $clog2(N_REQ);
    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST - 1);
    localparam logic [PTR_W-1:0]   OWNER_MAX = PTR_W'(N_REQ - 1);
    localparam logic [ADDR_BITS:0] CNT_MAX   = (ADDR_BITS + 1)'(MAX_DATA);

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t            r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_grant, w_grant_nxt;
    logic [PTR_W-1:0]  r_owner, w_owner_nxt;
    logic [PTR_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [BEAT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic [PTR_W-1:0]  w_win;
    logic              w_win_found;
    logic              w_xfer;
    logic              w_owner_valid;
    logic              w_accept;
    logic              w_release;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    // Scan from rr_ptr upward; the first valid requester in that order wins.
    always_comb begin
        w_win       = '0;
        w_win_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_win_found && bus.req_valid[wrap_add(r_rr_ptr, k)]) begin
                w_win       = wrap_add(r_rr_ptr, k);
                w_win_found = 1'b1;
            end
        end
`ifdef ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            w_win       = '0;
            w_win_found = 1'b1;
        end
`endif
    end

    assign w_xfer        = (r_state == S_XFER);
    assign w_owner_valid = bus.req_valid[r_owner];
    assign w_accept      = w_xfer && w_owner_valid && !bus.fifo_full && (bus.fifo_count < CNT_MAX);
    // A full stall never counts as an idle owner, so it cannot release.
    assign w_release     = (w_accept && (bus.req_last[r_owner] || (r_beat_cnt == BEAT_LAST)))
                         || (w_xfer && !w_owner_valid && !bus.fifo_full);

    assign bus.fifo_wen   = w_accept;
    assign bus.fifo_wdata = w_xfer ? bus.req_data[8*int'(r_owner) +: 8] : 8'h00;
    assign bus.req_ready  = w_accept ? r_grant : '0;
    assign bus.grant      = r_grant;
    assign bus.busy       = w_xfer;

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt    = S_XFER;
                    w_grant_nxt    = N_REQ'(1) << w_win;
                    w_owner_nxt    = w_win;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_XFER: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
`ifdef ARB_PRIO0_EN
                    if (r_owner != '0)
                        w_rr_ptr_nxt = (r_owner == OWNER_MAX) ? '0 : r_owner + 1'b1;
`else
                    w_rr_ptr_nxt = (r_owner == OWNER_MAX) ? '0 : r_owner + 1'b1;
`endif
                end else if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;
    localparam int N   = 4;
    localparam int MAX = 16;
    localparam int AB  = 5;
    localparam int BST = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.N_REQ(N), .ADDR_BITS(AB)) bus ();

    fifo_write_arbiter #(.N_REQ(N), .MAX_DATA(MAX), .ADDR_BITS(AB), .BURST(BST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] pq [N][$];
    bit  en [N];
    int  fcount;
    int  rd_pct;
    int  wcount = 0;
    bit  m_busy;
    int  m_owner, m_ptr, m_beats;
    int  glog[$];
    int  blog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
        int best, bd, d;
        best = -1;
        bd   = N + 1;
`ifdef ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - m_ptr + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic push_pkt(input int r, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) pq[r].push_back({(k == n - 1) ? 1'b1 : 1'b0, base + 8'(k)});
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (en[i] && pq[i].size() > 0) begin
                bus.req_valid[i]       = 1'b1;
                bus.req_data[8*i +: 8] = pq[i][0][7:0];
                bus.req_last[i]        = pq[i][0][8];
            end else begin
                bus.req_valid[i]       = 1'b0;
                bus.req_data[8*i +: 8] = 8'($urandom);
                bus.req_last[i]        = 1'($urandom);
            end
        end
        bus.fifo_full  = (fcount >= MAX);
        bus.fifo_count = (AB + 1)'(fcount);
    endtask

    task automatic release_owner();
        m_busy = 1'b0;
`ifdef ARB_PRIO0_EN
        if (m_owner != 0) m_ptr = (m_owner + 1) % N;
`else
        m_ptr = (m_owner + 1) % N;
`endif
    endtask

    // One clock: check outputs against the model mid-cycle, then advance model at the edge.
    task automatic step();
        logic [N-1:0] v;
        bit acc, lst, full, rd;
        logic [7:0] d;
        drive();
        #1;
        v    = bus.req_valid;
        full = (fcount >= MAX);
        acc  = 1'b0;
        lst  = 1'b0;
        d    = 8'h00;
        if (m_busy) begin
            acc = v[m_owner] && !full;
            d   = bus.req_data[8*m_owner +: 8];
            lst = bus.req_last[m_owner];
        end
        chk("grant", 32'(bus.grant), m_busy ? 32'(1 << m_owner) : 32'd0);
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("fifo_wen", 32'(bus.fifo_wen), 32'(acc));
        chk("req_ready", 32'(bus.req_ready), acc ? 32'(1 << m_owner) : 32'd0);
        if (acc) chk("fifo_wdata", 32'(bus.fifo_wdata), 32'(d));
        @(posedge clk);
        rd = ($urandom_range(0, 99) < rd_pct) && (fcount > 0);
        if (acc) begin
            void'(pq[m_owner].pop_front());
            wcount++;
            blog[blog.size()-1]++;
        end
        fcount = fcount + int'(acc) - int'(rd);
        if (!m_busy) begin
            if (v != '0) begin
                m_owner = pick(v);
                m_busy  = 1'b1;
                m_beats = 0;
                glog.push_back(m_owner);
                blog.push_back(0);
            end
        end else if (acc) begin
            m_beats++;
            if (lst || m_beats == BST) release_owner();
        end else if (!v[m_owner] && !full) begin
            release_owner();
        end
        @(negedge clk);
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (en[i] && pq[i].size() > 0) return 1'b1;
        return m_busy;
    endfunction

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (pending() && n < limit) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", 32'(pending()), 32'd0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1;
            pq[i].delete();
        end
        fcount = 0;
        rd_pct = 50;
        drive();
        @(posedge clk);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_wen", 32'(bus.fifo_wen), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wdata", 32'(bus.fifo_wdata), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_busy  = 1'b0;
        m_ptr   = 0;
        m_owner = 0;
        glog.delete();
        blog.delete();
    endtask

    initial begin
        int w0, n;
        int exp_g[$];
        rst_n = 1'b1;
        #2;

        // Single 3-beat packet on requester 0, then rr_ptr moved past it.
        reset_dut();
        push_pkt(0, 3, 8'hA1);
        w0 = wcount;
        step();
        chk("t1_grant_c1", 32'(bus.grant), 32'd1);
        step(); step(); step();
        chk("t1_released", 32'(bus.grant), 32'd0);
        chk("t1_writes", 32'(wcount - w0), 32'd3);
        push_pkt(0, 1, 8'h10);
        push_pkt(1, 1, 8'h20);
        wait_idle(50);
        chk("t1_next_owner", 32'(glog[1]), 32'd1);

        // All four requesters with 6-beat packets.
        reset_dut();
        for (int i = 0; i < N; i++) push_pkt(i, 6, 8'(8'h30 + 8'(16 * i)));
        wait_idle(400);
        chk("t2_grants", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            chk("t2_order", 32'(glog[i]), 32'(i % 4));
            chk("t2_beats", 32'(blog[i]), (i < 4) ? 32'd4 : 32'd2);
        end

        // Near-full fifo stalls the owner until reads resume.
        reset_dut();
        fcount = 15;
        rd_pct = 0;
        push_pkt(0, 3, 8'hC0);
        for (int i = 0; i < 8; i++) step();
        chk("t3_grant_held", 32'(bus.grant), 32'd1);
        chk("t3_busy_held", 32'(bus.busy), 32'd1);
        chk("t3_remaining", 32'(pq[0].size()), 32'd2);
        rd_pct = 100;
        wait_idle(100);
        chk("t3_drained", 32'(pq[0].size()), 32'd0);
        chk("t3_one_grant", 32'(glog.size()), 32'd1);

        // Owner drops valid after 2 beats.
        reset_dut();
        push_pkt(0, 4, 8'h40);
        push_pkt(1, 2, 8'h50);
        step(); step(); step();
        en[0] = 1'b0;
        step();
        chk("t4_release", 32'(bus.grant), 32'd0);
        step();
        chk("t4_next_grant", 32'(bus.grant), 32'd2);
        en[0] = 1'b1;
        wait_idle(100);
        chk("t4_first_beats", 32'(blog[0]), 32'd2);

        // Async reset during beat 2 of requester 2's burst; rr_ptr must return to 0.
        reset_dut();
        push_pkt(1, 1, 8'h60);
        wait_idle(50);
        push_pkt(2, 4, 8'h70);
        step(); step();
        drive();
        #1;
        chk("t5_wen_before", 32'(bus.fifo_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_wen", 32'(bus.fifo_wen), 32'd0);
        chk("t5_async_ready", 32'(bus.req_ready), 32'd0);
        chk("t5_async_grant", 32'(bus.grant), 32'd0);
        chk("t5_async_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_busy = 1'b0;
        m_ptr  = 0;
        glog.delete();
        blog.delete();
        for (int i = 0; i < N; i++) pq[i].delete();
        push_pkt(0, 1, 8'h80);
        push_pkt(3, 1, 8'h90);
        wait_idle(50);
        chk("t5_first_after_rst", 32'(glog[0]), 32'd0);

        // Requester 0 raises valid while requester 2 is mid-burst.
        reset_dut();
        for (int i = 1; i < N; i++) push_pkt(i, 4, 8'(8'hA0 + 8'(16 * i)));
        n = 0;
        while (glog.size() < 2 && n < 50) begin
            step();
            n++;
        end
        step();
        push_pkt(0, 2, 8'h05);
        wait_idle(200);
`ifdef ARB_PRIO0_EN
        exp_g = '{1, 2, 0, 3};
`else
        exp_g = '{1, 2, 3, 0};
`endif
        chk("t6_grants", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("t6_order", 32'(glog[i]), 32'(exp_g[i]));
        chk("t6_r2_burst", 32'(blog[1]), 32'd4);

        // Randomized traffic with varying fifo drain rate.
        reset_dut();
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) rd_pct = $urandom_range(20, 100);
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(0, N - 1);
                if (pq[n].size() < 10) push_pkt(n, $urandom_range(1, 6), 8'($urandom));
            end
            step();
        end
        rd_pct = 60;
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
